// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module   : seg_scan_driver
// Brief    : 4-digit multiplexed 7-segment scanner with per-slot anti-ghost blanking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg_scan_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] ad_nib,
  input  logic [3:0] blank_mask,
  input  logic [3:0] dp_mask,
  output logic [1:0] seg_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int            CW          = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] C_LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_BLANK_END = CW'(BLANK_CYC - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] w_cnt;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;
  logic          paused_q, paused_d;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // After a pause the held count is ignored so the same digit restarts a full slot.
  assign w_cnt = paused_q ? '0 : cnt_q;

  always_comb begin
    cnt_d    = cnt_q;
    state_d  = state_q;
    sel_d    = sel_q;
    fd_d     = 1'b0;
    paused_d = paused_q;
    an_d     = 4'hF;
    seg_d    = f_decode(ad_nib);
    dp_d     = ~dp_mask[sel_q];

    if (!enable) begin
      state_d  = ST_BLANK;
      paused_d = 1'b1;
    end else begin
      paused_d = 1'b0;
      if (w_cnt == C_LAST) begin
        cnt_d   = '0;
        sel_d   = sel_q + 2'd1;
        state_d = ST_BLANK;
        fd_d    = (sel_q == 2'd3);
      end else begin
        cnt_d = w_cnt + CW'(1);
        if (state_q == ST_BLANK && w_cnt == C_BLANK_END) begin
          state_d = ST_SHOW;
        end
      end
      // Anode decode is one-hot by construction, so no two digits can ever be lit.
      if (state_d == ST_SHOW && !blank_mask[sel_d]) begin
        an_d = ~(4'b0001 << sel_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BLANK;
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      an_q     <= 4'hF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
      paused_q <= paused_d;
    end
  end

  assign seg_sel    = sel_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Directed self-checking bench for seg_scan_driver (DIV=8, BLANK=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

  localparam int DIV = 8;
  localparam int BLK = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] ad_nib;
  logic [3:0] blank_mask;
  logic [3:0] dp_mask;
  logic [1:0] seg_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int         vec  = 0;
  int         errs = 0;
  int         pos  = 0;
  logic       mux_mode;
  logic [3:0] nib_manual;

  logic [3:0] MUXTBL [4]  = '{4'h3, 4'hA, 4'hF, 4'h8};
  logic [6:0] DEC    [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  // Mux model: returns the nibble for the digit currently selected.
  assign ad_nib = mux_mode ? MUXTBL[seg_sel] : nib_manual;

  seg_scan_driver #(
    .REFRESH_DIV (DIV),
    .BLANK_CYC   (BLK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ad_nib     (ad_nib),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .seg_sel    (seg_sel),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals();
    chk("rst_seg_sel", 32'(seg_sel), 32'd0);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
  endtask

  task automatic check_scan(input bit chk_seg);
    int         c;
    int         s;
    bit         lit;
    logic [3:0] exp_an;
    logic       exp_dp;
    c      = pos % DIV;
    s      = (pos / DIV) % 4;
    lit    = (c >= BLK) && !blank_mask[s];
    exp_an = lit ? ~(4'b0001 << s) : 4'hF;
    exp_dp = ~dp_mask[s];
    chk("seg_sel", 32'(seg_sel), 32'(s));
    chk("an", 32'(an), 32'(exp_an));
    chk("frame_done", 32'(frame_done), 32'(c == 0 && s == 0 && pos != 0));
    if (c >= BLK) begin
      chk("dp", 32'(dp), 32'(exp_dp));
      if (chk_seg) chk("seg", 32'(seg), 32'(DEC[MUXTBL[s]]));
    end
  endtask

  task automatic run(input int n, input bit chk_seg);
    repeat (n) begin
      step();
      pos++;
      check_scan(chk_seg);
    end
  endtask

  always @(negedge clk) begin
    vec++;
    assert ($countones(~an) <= 1) else begin
      errs++;
      $error("FAIL onehot_an observed=%0h expected=at_most_one_low", an);
    end
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    blank_mask = 4'h0;
    dp_mask    = 4'h0;
    mux_mode   = 1'b1;
    nib_manual = 4'h0;

    // Reset held for three edges
    repeat (3) step();
    check_reset_vals();
    reset = 1'b0;
    pos   = 0;
    run(2, 1'b1);

    // One full frame
    run(32, 1'b1);

    // Decode sweep on a directly driven nibble
    mux_mode = 1'b0;
    for (int v = 0; v < 16; v++) begin
      nib_manual = 4'(v);
      step();
      pos++;
      chk("decode", 32'(seg), 32'(DEC[v]));
      check_scan(1'b0);
    end
    mux_mode = 1'b1;

    // Blank and decimal-point masks over a full frame
    blank_mask = 4'b0100;
    dp_mask    = 4'b0001;
    run(32, 1'b1);
    blank_mask = 4'h0;
    dp_mask    = 4'h0;

    // Pause mid-slot 1 (cnt=4) for ten cycles, then resume
    run((12 - (pos % 32) + 32) % 32, 1'b1);
    enable = 1'b0;
    repeat (10) begin
      step();
      chk("pause_an", 32'(an), 32'hF);
      chk("pause_seg_sel", 32'(seg_sel), 32'd1);
      chk("pause_frame_done", 32'(frame_done), 32'd0);
    end
    enable = 1'b1;
    pos    = pos - (pos % DIV);
    run(8, 1'b1);

    // Reset while showing digit 3
    run((28 - (pos % 32) + 32) % 32, 1'b1);
    reset = 1'b1;
    step();
    check_reset_vals();
    reset = 1'b0;
    pos   = 0;
    run(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Drives the 4-digit 7-segment display from the DisplayController.
- Generates the digit-select code `seg_sel` that steers the address/data nibble multiplexer, and takes the selected nibble back from it.
- Decodes that nibble to active-low cathodes and drives active-low anodes.
- Inserts a blanking gap at each digit change to suppress ghosting.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot (100 MHz gives 2 kHz per digit, 500 Hz per frame). Must be >= 4.
- BLANK_CYC, 4: cycles at the start of each slot with all anodes off. Must be >= 1 and < REFRESH_DIV.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan enable; 0 freezes the scan and blanks the display.
- ad_nib  input  4  nibble returned by the mux for the current `seg_sel`.
- blank_mask  input  4  bit i=1 keeps digit i dark.
- dp_mask  input  4  bit i=1 lights the decimal point on digit i.
- seg_sel  output  2  digit select to the mux: 0=d_lo, 1=d_hi, 2=ad_lo, 3=ad_hi.
- an  output  4  anodes, active-low; an[i] drives digit i.
- seg  output  7  cathodes, active-low; seg[0]=a ... seg[6]=g.
- dp  output  1  decimal point, active-low.
- frame_done  output  1  one-cycle pulse when `seg_sel` wraps 3->0.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - All outputs are registered.
- Reset values (in the cycle after `reset` is sampled high):
  - seg_sel=2'b00, an=4'b1111, seg=7'h7F, dp=1, frame_done=0.
  - Slot counter cnt=0; state=BLANK.
- Slot counter:
  - When enable=1, cnt counts 0..REFRESH_DIV-1.
  - At cnt=REFRESH_DIV-1: cnt->0, seg_sel->seg_sel+1 (mod 4), state->BLANK, an->4'b1111, all in the same edge.
- State machine:
  - BLANK: an=1111. When cnt reaches BLANK_CYC-1, go to SHOW on the next edge.
  - SHOW: an = ~(4'b0001 << seg_sel), or 1111 if blank_mask[seg_sel]=1. Stay in SHOW until slot end.
- First lit cycle:
  - The first lit cycle of each slot is cycle BLANK_CYC after the slot start.
  - This gives the mux and decoder at least BLANK_CYC cycles to settle.
- Cathodes:
  - seg is registered every clock from the decode of ad_nib.
  - dp = ~dp_mask[seg_sel], registered.
  - seg/dp lag ad_nib by 1 cycle; this is hidden by the BLANK window.
- Decode, active-low, indexed by ad_nib value:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- frame_done:
  - High for exactly one cycle, on the edge where seg_sel goes 3->0.
  - Never asserted while enable=0.
- enable=0:
  - cnt and seg_sel hold; state->BLANK; an=1111 from the next cycle.
  - On return to 1: cnt restarts at 0 in BLANK on the same seg_sel. That digit gets a full slot.
- Asynchronous-looking input changes:
  - blank_mask and dp_mask changes take effect on the next edge.
  - ad_nib changes take effect on the next edge.
  - No input latching beyond the one-cycle register.
- Reset mid-slot: overrides everything; outputs reach reset values on that edge.
- No two anodes are ever low in the same cycle, under any input sequence.

Test Plan:
(Bench uses REFRESH_DIV=8, BLANK_CYC=2.)
1. Reset check: assert reset 3 cycles with enable=1 -> seg_sel=0, an=1111, seg=7F, dp=1, frame_done=0. After release, an=1110 first appears in cycle 2 of slot 0.
2. Full scan: enable=1, masks=0, mux model returning nibbles {0:3, 1:A, 2:F, 3:8} -> 2-cycle BLANK at each slot start, then the following lit patterns:
   - slot 0: an=1110 with seg=30
   - slot 1: an=1101 with seg=08
   - slot 2: an=1011 with seg=0E
   - slot 3: an=0111 with seg=00
   - each lit pattern holds for 6 cycles.
   - frame_done pulses once every 32 cycles.
3. Decode sweep: for ad_nib=0..F in turn, seg matches the 16-entry table one cycle later.
4. Masks: blank_mask=0100, dp_mask=0001 -> an stays 1111 throughout slot 2; dp=0 only during slot 0; seg_sel still advances.
5. Enable pause: drop enable mid-slot 1 for 10 cycles -> an=1111 next cycle, seg_sel stays 1, no frame_done. On resume: 2 BLANK cycles, then 6 lit cycles on digit 1.
6. Reset mid-SHOW in slot 3 -> next cycle seg_sel=0, an=1111. Scoreboard confirms an never has more than one zero bit across all tests.
